// File: rtl/cordic_phase_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_phase_encoder_param
//  Brief    : CORDIC phase front end. Folds a phase word to octant plus
//             residual, then greedily decomposes the residual into signed
//             power-of-two micro-rotation codes, one per cycle, and writes
//             each code (tagged with channel and octant) into the rotator FIFO.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module cordic_phase_encoder_param #(
  parameter int PHASE_W    = 24,
  parameter int CH_W       = 2,
  parameter int MAX_STEPS  = 12,
  parameter int EARLY_STOP = 1,
  parameter int TOL_SH     = 0
) (
  input  logic                                    iClk,
  input  logic                                    iReset_n,
  input  logic                                    iData_valid,
  input  logic [PHASE_W-1:0]                      iData,
  input  logic [CH_W-1:0]                         iChan,
  input  logic                                    iFifo_almost_full,
  output logic                                    oReady,
  output logic                                    oBusy,
  output logic [CH_W+6+$clog2(PHASE_W-2)-1:0]     oFifo_data,
  output logic                                    oFifo_write_request
);

  localparam int RES_W  = PHASE_W - 2;
  localparam int F_W    = PHASE_W - 3;
  localparam int ADDR_W = $clog2(RES_W);
  localparam int OUT_W  = CH_W + 6 + ADDR_W;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_NORM = 2'd1;
  localparam logic [1:0] c_ITER = 2'd2;

  logic [1:0]         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [CH_W-1:0]    r_chan;
  logic [2:0]         r_oct;
  logic [RES_W:0]     r_res;      // two's complement residual, MSB is sign
  logic [ADDR_W-1:0]  r_cnt;
  logic               r_wr;
  logic [OUT_W-1:0]   r_data;

  logic [RES_W:0]     w_fold;
  logic [RES_W-1:0]   w_mag;
  logic [ADDR_W-1:0]  w_lead;
  logic               w_rnd;
  logic               w_zero;
  logic [ADDR_W-1:0]  w_p;
  logic [RES_W:0]     w_ang;
  logic               w_sign;
  logic [ADDR_W-1:0]  w_addr;
  logic [RES_W:0]     w_res_next;
  logic [RES_W-1:0]   w_next_mag;
  logic               w_final;
  logic               w_tol;
  logic [1:0]         w_last;

  // Fold odd octants so the residual always measures distance from the
  // nearest octant edge in the rotation direction.
  always_comb begin
    w_fold = (RES_W+1)'(r_phase[F_W-1:0]);
    if (r_phase[F_W]) begin
      w_fold = ((RES_W+1)'(1) << F_W) - (RES_W+1)'(r_phase[F_W-1:0]);
    end
  end

  // Leading-one search on |r| with the bit below it used for round-to-nearest.
  always_comb begin
    w_mag  = r_res[RES_W] ? RES_W'(-r_res) : RES_W'(r_res);
    w_lead = '0;
    w_rnd  = 1'b0;
    for (int i = 1; i < RES_W; i++) begin
      if (w_mag[i]) begin
        w_lead = ADDR_W'(i);
        w_rnd  = w_mag[i-1];
      end
    end
  end

  // Digit selection, residual update and last-code classification.
  always_comb begin
    w_zero     = (r_res == '0);
    w_p        = w_lead + ADDR_W'(w_rnd);
    w_ang      = (RES_W+1)'(1) << w_p;
    w_sign     = ~w_zero & r_res[RES_W];
    w_addr     = w_zero ? '1 : (ADDR_W'(RES_W-1) - w_p);
    w_res_next = '0;
    if (!w_zero) begin
      w_res_next = w_sign ? (r_res + w_ang) : (r_res - w_ang);
    end
    w_next_mag = w_res_next[RES_W] ? RES_W'(-w_res_next) : RES_W'(w_res_next);
    w_final    = (r_cnt == ADDR_W'(MAX_STEPS-1));
    w_tol      = (TOL_SH > 0) && (w_next_mag != '0) && ((w_next_mag >> TOL_SH) == '0);
    w_last     = 2'b00;
    if (EARLY_STOP != 0) begin
      if (w_res_next == '0)  w_last = 2'b01;
      else if (w_tol)        w_last = 2'b11;
      else if (w_final)      w_last = 2'b10;
    end else if (w_final) begin
      w_last = (w_res_next == '0) ? 2'b01 : 2'b10;
    end
  end

  // Transaction sequencer: capture, normalise, then emit one code per
  // un-stalled cycle until a terminating last code.
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_state <= c_IDLE;
      r_phase <= '0;
      r_chan  <= '0;
      r_oct   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_wr <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (iData_valid) begin
            r_phase <= iData;
            r_chan  <= iChan;
            r_state <= c_NORM;
          end
        end
        c_NORM: begin
          r_oct   <= r_phase[PHASE_W-1 -: 3];
          r_res   <= w_fold;
          r_cnt   <= '0;
          r_state <= c_ITER;
        end
        c_ITER: begin
          if (!iFifo_almost_full) begin
            r_wr   <= 1'b1;
            r_data <= {r_chan, r_oct, w_last, w_sign, w_addr};
            r_res  <= w_res_next;
            r_cnt  <= r_cnt + ADDR_W'(1);
            if (w_last != 2'b00) begin
              r_state <= c_IDLE;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign oReady              = iReset_n && (r_state == c_IDLE);
  assign oBusy               = (r_state != c_IDLE);
  assign oFifo_data          = r_data;
  assign oFifo_write_request = r_wr;

endmodule
`default_nettype wire

// File: tb/tb_cordic_phase_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_phase_encoder_param
//  Brief    : Scoreboard bench for three encoder configurations sharing one
//             stimulus stream; expected codes come from an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_encoder_param;

  localparam int PW = 24;
  localparam int CW = 2;
  localparam int OW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [PW-1:0] data;
  logic [CW-1:0] chan;
  logic          af;

  logic ready_a, busy_a, wr_a;  logic [OW-1:0] fd_a;
  logic ready_b, busy_b, wr_b;  logic [OW-1:0] fd_b;
  logic ready_c, busy_c, wr_c;  logic [OW-1:0] fd_c;

  int errors = 0;
  int checks = 0;
  int nwr_a = 0, nwr_b = 0, nwr_c = 0;
  logic [OW-1:0] qa[$], qb[$], qc[$];
  bit rand_af = 1'b0;

  always #5 clk = ~clk;

  // A: step cap 8, early stop. B: fixed length 4. C: step cap 12, tolerance 3.
  cordic_phase_encoder_param #(.PHASE_W(PW), .CH_W(CW), .MAX_STEPS(8), .EARLY_STOP(1), .TOL_SH(0)) dut_a (
    .iClk(clk), .iReset_n(rst_n), .iData_valid(valid), .iData(data), .iChan(chan),
    .iFifo_almost_full(af), .oReady(ready_a), .oBusy(busy_a), .oFifo_data(fd_a),
    .oFifo_write_request(wr_a));
  cordic_phase_encoder_param #(.PHASE_W(PW), .CH_W(CW), .MAX_STEPS(4), .EARLY_STOP(0), .TOL_SH(0)) dut_b (
    .iClk(clk), .iReset_n(rst_n), .iData_valid(valid), .iData(data), .iChan(chan),
    .iFifo_almost_full(af), .oReady(ready_b), .oBusy(busy_b), .oFifo_data(fd_b),
    .oFifo_write_request(wr_b));
  cordic_phase_encoder_param #(.PHASE_W(PW), .CH_W(CW), .MAX_STEPS(12), .EARLY_STOP(1), .TOL_SH(3)) dut_c (
    .iClk(clk), .iReset_n(rst_n), .iData_valid(valid), .iData(data), .iChan(chan),
    .iFifo_almost_full(af), .oReady(ready_c), .oBusy(busy_c), .oFifo_data(fd_c),
    .oFifo_write_request(wr_c));

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: nearest power-of-two decomposition of the folded residual.
  task automatic model(input int id, input logic [PW-1:0] ph, input logic [CW-1:0] ch);
    int ms, es, tol, oct, n, lv, p, lst, sgn, adr;
    longint r, m, rn, mn;
    logic [OW-1:0] w;
    bit done;
    case (id)
      0:       begin ms = 8;  es = 1; tol = 0; end
      1:       begin ms = 4;  es = 0; tol = 0; end
      default: begin ms = 12; es = 1; tol = 3; end
    endcase
    oct = int'(ph[23:21]);
    r   = longint'(ph[20:0]);
    if (oct % 2 == 1) r = (longint'(1) << 21) - r;
    n = 0;
    done = 1'b0;
    while (!done && n < 64) begin
      n++;
      if (r == 0) begin
        sgn = 0; adr = 31; rn = 0;
      end else begin
        m  = (r < 0) ? -r : r;
        lv = 0;
        while ((longint'(1) << (lv + 1)) <= m) lv++;
        p = lv;
        if (lv > 0 && 2 * m >= 3 * (longint'(1) << lv)) p = lv + 1;
        adr = 21 - p;
        sgn = (r < 0) ? 1 : 0;
        rn  = (sgn == 1) ? r + (longint'(1) << p) : r - (longint'(1) << p);
      end
      mn = (rn < 0) ? -rn : rn;
      if (es != 0) begin
        if (rn == 0)                                 lst = 1;
        else if (tol > 0 && mn < (longint'(1) << tol)) lst = 3;
        else if (n == ms)                            lst = 2;
        else                                         lst = 0;
        done = (lst != 0);
      end else begin
        lst  = (n == ms) ? ((rn == 0) ? 1 : 2) : 0;
        done = (n == ms);
      end
      w = {ch, oct[2:0], lst[1:0], sgn[0], adr[4:0]};
      case (id)
        0:       qa.push_back(w);
        1:       qb.push_back(w);
        default: qc.push_back(w);
      endcase
      r = rn;
    end
  endtask

  task automatic pop_cmp(input int id, input logic [OW-1:0] got);
    logic [OW-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (id)
      0:       if (qa.size() > 0) begin have = 1'b1; e = qa.pop_front(); end
      1:       if (qb.size() > 0) begin have = 1'b1; e = qb.pop_front(); end
      default: if (qc.size() > 0) begin have = 1'b1; e = qc.pop_front(); end
    endcase
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL code_%0d: got write 0x%0h expected no write", id, got);
    end else begin
      check($sformatf("code_%0d", id), got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_af) af = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic [PW-1:0] ph, input logic [CW-1:0] ch);
    int k;
    k = 0;
    while (!(ready_a && ready_b && ready_c) && k < 400) begin
      tick();
      k++;
    end
    check("ready_wait", longint'(ready_a && ready_b && ready_c), 1);
    model(0, ph, ch);
    model(1, ph, ch);
    model(2, ph, ch);
    valid = 1'b1;
    data  = ph;
    chan  = ch;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    int base, k, sa, sb, sc;
    logic [PW-1:0] ph;
    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (wr_a) begin nwr_a++; pop_cmp(0, fd_a); end
          if (wr_b) begin nwr_b++; pop_cmp(1, fd_b); end
          if (wr_c) begin nwr_c++; pop_cmp(2, fd_c); end
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst_n = 1'b0; valid = 1'b0; data = '0; chan = '0; af = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_wr", wr_a, 0);
    check("rst_data", fd_a, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", ready_a, 1);

    // Zero phase: single null code, first write three cycles after accept.
    send(24'h000000, 2'd1);
    check("busy_norm", busy_a, 1);
    check("lat_t1", wr_a, 0);
    tick();
    check("lat_t2", wr_a, 0);
    tick();
    check("lat_t3", wr_a, 1);
    check("ready_again", ready_a, 1);

    send(24'h000003, 2'd0);
    send(24'h200001, 2'd3);
    send(24'h155555, 2'd2);

    // Back-pressure from the first ITER cycle for five cycles.
    send(24'h000003, 2'd0);
    tick();
    af = 1'b1;
    sa = nwr_a; sb = nwr_b; sc = nwr_c;
    repeat (5) tick();
    check("hold_busy", busy_a, 1);
    af = 1'b0;
    tick();
    check("hold_no_write", nwr_a + nwr_b + nwr_c, sa + sb + sc);
    check("release_write", wr_a, 1);

    // Reset while the third code is on the output.
    send(24'h155555, 2'd1);
    base = nwr_a;
    k = 0;
    while (nwr_a - base < 2 && k < 50) begin tick(); k++; end
    check("rst_wait", longint'(nwr_a - base >= 2), 1);
    rst_n = 1'b0;
    tick();
    check("abort_wr", wr_a | wr_b | wr_c, 0);
    check("abort_busy", busy_a | busy_b | busy_c, 0);
    check("abort_data", fd_a, 0);
    rst_n = 1'b1;
    qa.delete(); qb.delete(); qc.delete();
    #1;
    check("abort_ready", ready_a, 1);
    repeat (3) begin
      tick();
      check("post_rst_wr", wr_a | wr_b | wr_c, 0);
      check("post_rst_busy", busy_a, 0);
    end

    // Randomised phases with random back-pressure.
    rand_af = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ph = PW'($urandom);
      case ($urandom_range(0, 3))
        0:       ph = {ph[23:21], 13'h0, ph[7:0]};
        1:       ph = {ph[23:21], 21'h0};
        2:       ph = {ph[23:21], 16'hFFFF, ph[4:0]};
        default: ;
      endcase
      send(ph, CW'($urandom));
    end
    rand_af = 1'b0;
    af = 1'b0;
    k = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && k < 600) begin tick(); k++; end
    check("drain", qa.size() + qb.size() + qc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
